// File: rtl/op_decoder.sv
// Receive-side decoder for 40-bit MSB-first command frames on the monitor/sound serial link.
// Deserializes strobed bits, decodes the opcode byte and drives the audio datapath controls.
module op_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_bit,
    input  logic        in_bit_valid,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic        sample_valid,
    output logic        audio_enable,
    output logic        audio_rate_44k,
    output logic        audio_mono,
    output logic [5:0]  volume_l,
    output logic [5:0]  volume_r,
    output logic        power_query,
    output logic        frame_error,
    output logic [7:0]  error_count
);

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

    localparam logic [7:0] OP_SAMPLE = 8'h07;
    localparam logic [7:0] OP_START  = 8'hC5;
    localparam logic [7:0] OP_STOP   = 8'hC4;
    localparam logic [7:0] OP_VOLUME = 8'hC3;
    localparam logic [7:0] OP_POWER  = 8'hC6;

    // Abort fires on the strobe-free clock that would carry the idle count to TIMEOUT_CYCLES.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [39:0] frame_q;
    logic [5:0]  bit_cnt_q;
    logic [7:0]  timeout_cnt_q;
    logic [7:0]  opcode;

    logic start_frame, shift_bit, abort_frame;
    logic do_sample, do_start, do_stop, do_volume, do_power, bad_opcode, error_event;

    assign opcode = frame_q[39:32];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        state_d     = state_q;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        abort_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_bit_valid && in_bit) begin
                    start_frame = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                // A strobe on the terminal-count cycle wins over the timeout.
                if (in_bit_valid) begin
                    shift_bit = 1'b1;
                    if (bit_cnt_q == 6'd39) state_d = DECODE;
                end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    abort_frame = 1'b1;
                    state_d     = IDLE;
                end
            end
            DECODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_sample  = 1'b0;
        do_start   = 1'b0;
        do_stop    = 1'b0;
        do_volume  = 1'b0;
        do_power   = 1'b0;
        bad_opcode = 1'b0;
        if (state_q == DECODE) begin
            case (opcode)
                OP_SAMPLE: do_sample  = audio_enable;
                OP_START:  do_start   = 1'b1;
                OP_STOP:   do_stop    = 1'b1;
                OP_VOLUME: do_volume  = 1'b1;
                OP_POWER:  do_power   = 1'b1;
                default:   bad_opcode = 1'b1;
            endcase
        end
        error_event = abort_frame | bad_opcode;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            timeout_cnt_q <= '0;
        end else if (start_frame) begin
            bit_cnt_q     <= '0;
            timeout_cnt_q <= '0;
        end else if (shift_bit) begin
            frame_q       <= {frame_q[38:0], in_bit};
            bit_cnt_q     <= bit_cnt_q + 6'd1;
            timeout_cnt_q <= '0;
        end else if (state_q == SHIFT) begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_l       <= '0;
            sample_r       <= '0;
            sample_valid   <= 1'b0;
            audio_enable   <= 1'b0;
            audio_rate_44k <= 1'b0;
            audio_mono     <= 1'b0;
            volume_l       <= '0;
            volume_r       <= '0;
            power_query    <= 1'b0;
            frame_error    <= 1'b0;
            error_count    <= '0;
        end else begin
            sample_valid <= do_sample;
            power_query  <= do_power;
            frame_error  <= error_event;
            if (do_sample) begin
                sample_l <= frame_q[31:16];
                sample_r <= frame_q[15:0];
            end
            if (do_start) begin
                audio_enable   <= 1'b1;
                audio_rate_44k <= frame_q[24];
                audio_mono     <= frame_q[25];
            end
            if (do_stop) audio_enable <= 1'b0;
            if (do_volume) begin
                volume_l <= frame_q[29:24];
                volume_r <= frame_q[21:16];
            end
            if (error_event && error_count != 8'hFF) error_count <= error_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_op_decoder.sv
// Self-checking bench for op_decoder: directed frames, timeout cases, randomized frames and
// error-count saturation, all checked against a frame-level reference model.
module tb_op_decoder;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_bit_valid = 1'b0;
    logic [15:0] sample_l, sample_r;
    logic        sample_valid, audio_enable, audio_rate_44k, audio_mono;
    logic [5:0]  volume_l, volume_r;
    logic        power_query, frame_error;
    logic [7:0]  error_count;

    int checks = 0;
    int errors = 0;

    // Reference model of the architectural outputs.
    logic [15:0] m_sl, m_sr;
    logic        m_en, m_rate, m_mono;
    logic [5:0]  m_vl, m_vr;
    int          m_ec;

    op_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_bit_valid(in_bit_valid),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .audio_enable(audio_enable), .audio_rate_44k(audio_rate_44k), .audio_mono(audio_mono),
        .volume_l(volume_l), .volume_r(volume_r), .power_query(power_query),
        .frame_error(frame_error), .error_count(error_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sl = '0; m_sr = '0; m_en = 1'b0; m_rate = 1'b0; m_mono = 1'b0;
        m_vl = '0; m_vr = '0; m_ec = 0;
    endtask

    task automatic model_error();
        if (m_ec < 255) m_ec++;
    endtask

    task automatic model_frame(input logic [39:0] f, output bit e_sv, output bit e_pq, output bit e_fe);
        logic [7:0] op;
        op = f[39:32];
        e_sv = 0; e_pq = 0; e_fe = 0;
        if (op == 8'h07) begin
            if (m_en) begin
                m_sl = f[31:16]; m_sr = f[15:0]; e_sv = 1;
            end
        end else if (op == 8'hC5) begin
            m_en = 1'b1; m_rate = f[24]; m_mono = f[25];
        end else if (op == 8'hC4) begin
            m_en = 1'b0;
        end else if (op == 8'hC3) begin
            m_vl = f[29:24]; m_vr = f[21:16];
        end else if (op == 8'hC6) begin
            e_pq = 1;
        end else begin
            e_fe = 1; model_error();
        end
    endtask

    task automatic compare_all(input string tag, input bit e_sv, input bit e_pq, input bit e_fe);
        check({tag, ".sample_l"}, 40'(sample_l), 40'(m_sl));
        check({tag, ".sample_r"}, 40'(sample_r), 40'(m_sr));
        check({tag, ".sample_valid"}, 40'(sample_valid), 40'(e_sv));
        check({tag, ".audio_enable"}, 40'(audio_enable), 40'(m_en));
        check({tag, ".audio_rate_44k"}, 40'(audio_rate_44k), 40'(m_rate));
        check({tag, ".audio_mono"}, 40'(audio_mono), 40'(m_mono));
        check({tag, ".volume_l"}, 40'(volume_l), 40'(m_vl));
        check({tag, ".volume_r"}, 40'(volume_r), 40'(m_vr));
        check({tag, ".power_query"}, 40'(power_query), 40'(e_pq));
        check({tag, ".frame_error"}, 40'(frame_error), 40'(e_fe));
        check({tag, ".error_count"}, 40'(error_count), 40'(m_ec));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        in_bit = b;
        in_bit_valid = 1'b1;
        @(negedge clk);
        in_bit_valid = 1'b0;
        in_bit = 1'b0;
    endtask

    // Start bit plus 40 data bits; optional random gaps and one long stall after stall_at data bits.
    task automatic send_frame(input logic [39:0] f, input int max_gap, input int stall_at, input int stall_len);
        send_bit(1'b1);
        for (int i = 39; i >= 0; i--) begin
            send_bit(f[i]);
            if (i > 0) begin
                if (40 - i == stall_at) idle(stall_len);
                else if (max_gap > 0) idle($urandom_range(max_gap, 0));
            end
        end
    endtask

    // Sends a frame, checks the DECODE cycle (nothing yet) and the following result cycle.
    task automatic do_frame(input string tag, input logic [39:0] f, input int max_gap,
                            input int stall_at, input int stall_len);
        bit e_sv, e_pq, e_fe;
        send_frame(f, max_gap, stall_at, stall_len);
        compare_all({tag, ".decode"}, 0, 0, 0);
        model_frame(f, e_sv, e_pq, e_fe);
        @(negedge clk);
        compare_all({tag, ".result"}, e_sv, e_pq, e_fe);
    endtask

    initial begin
        logic [39:0] f;
        logic [7:0]  op;

        model_reset();
        idle(3);
        compare_all("reset", 0, 0, 0);
        reset_n = 1'b1;
        idle(2);

        // Idle-line zeros are ignored.
        send_bit(1'b0);
        send_bit(1'b0);
        do_frame("start", 40'hC5_01_00_00_00, 0, 0, 0);
        do_frame("sample", 40'h07_1234_ABCD, 0, 0, 0);
        @(negedge clk);
        compare_all("sample.pulse_end", 0, 0, 0);
        do_frame("stop", 40'hC4_00_00_00_00, 0, 0, 0);
        do_frame("sample_disabled", 40'h07_5555_6666, 0, 0, 0);
        do_frame("volume", 40'hC3_2A_15_00_00, 0, 0, 0);
        do_frame("power", 40'hC6_71_00_00_00, 0, 0, 0);
        do_frame("bad_op", 40'h99_00_00_00_00, 1, 0, 0);
        check("bad_op.count_is_1", 40'(error_count), 40'd1);
        do_frame("start_mono", 40'hC5_02_00_00_00, 2, 0, 0);

        // Timeout: start + 20 data bits then silence.
        send_bit(1'b1);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom));
        idle(TO - 1);
        check("timeout.before", 40'(frame_error), 40'd0);
        @(negedge clk);
        model_error();
        compare_all("timeout.pulse", 0, 0, 1);
        @(negedge clk);
        compare_all("timeout.after", 0, 0, 0);
        do_frame("after_timeout", 40'hC6_00_00_00_00, 0, 0, 0);

        // Strobe exactly on the terminal-count cycle must be accepted.
        do_frame("terminal_strobe", 40'hC3_15_2A_00_00, 0, 20, TO - 1);

        // Randomized frames with random bit gaps and 0..2 idle clocks between frames.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(5, 0))
                0: op = 8'h07;
                1: op = 8'hC5;
                2: op = 8'hC4;
                3: op = 8'hC3;
                4: op = 8'hC6;
                default: op = 8'($urandom);
            endcase
            f = {op, 32'($urandom)};
            idle($urandom_range(2, 0));
            if ($urandom_range(3, 0) == 0) send_bit(1'b0);
            do_frame("random", f, 2, 0, 0);
        end

        // Reset mid-frame clears all outputs immediately.
        send_bit(1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("mid_reset", 0, 0, 0);
        idle(2);
        reset_n = 1'b1;
        @(negedge clk);
        do_frame("post_reset", 40'hC5_03_00_00_00, 0, 0, 0);

        // Error counter saturation.
        for (int n = 0; n < 300; n++) begin
            op = 8'($urandom);
            while (op == 8'h07 || op == 8'hC3 || op == 8'hC4 || op == 8'hC5 || op == 8'hC6)
                op = 8'($urandom);
            do_frame("saturate", {op, 32'($urandom)}, 0, 0, 0);
        end
        check("saturate.final", 40'(error_count), 40'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
